regfile_wb_arbiter: RTL and testbench

Writeback-side companion to the register file. Collects results from the single-cycle ALU, the load/store unit and the multiply/divide unit, arbitrates them onto the register file's single write port, and keeps a busy scoreboard of destinations with long-latency results still outstanding. Sits between the execute units and the register file; decode uses its scoreboard, hold and forwarding outputs for hazard control.

---
 rtl/wb_pkg.sv | 14 +
 rtl/wb_scoreboard.sv | 34 +++
 rtl/regfile_wb_arbiter.sv | 121 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared widths, defaults and source encoding for the writeback arbiter.
package wb_pkg;
  localparam int XLEN       = 32;
  localparam int NREG       = 32;
  localparam int AW         = $clog2(NREG);
  localparam int STARVE_LIM = 4;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LSU  = 2'd2,
    SRC_MDU  = 2'd3
  } wb_src_e;
endpackage

// File: rtl/wb_scoreboard.sv
// Busy vector for destinations with outstanding long-latency results.
module wb_scoreboard
  import wb_pkg::*;
#(
  parameter int NREG = wb_pkg::NREG,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  input  logic            reg_write,
  input  logic [AW-1:0]   rd,
  output logic [NREG-1:0] busy
);
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;
  logic [NREG-1:0] busy_nxt;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (iss_valid) set_vec[iss_rd] = 1'b1;
    if (reg_write) clr_vec[rd] = 1'b1;
    // Set is applied after clear so a reissue in the commit cycle keeps the bit.
    busy_nxt = (busy & ~clr_vec) | set_vec;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) busy <= '0;
    else         busy <= busy_nxt;
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU/LSU/MDU results onto the register file write port.
// Optional forwarding of the in-flight write: define REGFILE_WB_FORWARD_EN.
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN       = wb_pkg::XLEN,
  parameter int NREG       = wb_pkg::NREG,
  parameter int STARVE_LIM = wb_pkg::STARVE_LIM,
  parameter int AW         = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic            mdu_valid,
  output logic            mdu_ready,
  input  logic [AW-1:0]   mdu_rd,
  input  logic [XLEN-1:0] mdu_data,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  output logic            reg_write,
  output logic [AW-1:0]   rd,
  output logic [XLEN-1:0] write_data,
  output logic [NREG-1:0] busy,
`ifdef REGFILE_WB_FORWARD_EN
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            fwd1_hit,
  output logic            fwd2_hit,
  output logic [XLEN-1:0] fwd1_data,
  output logic [XLEN-1:0] fwd2_data,
`endif
  output logic            alu_hold
);
  localparam int CW = $clog2(STARVE_LIM + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == LIM) ? v : v + 1'b1;
  endfunction

  logic [CW-1:0]   lsu_cnt;
  logic [CW-1:0]   mdu_cnt;
  logic            lsu_aged;
  logic            mdu_aged;
  logic            lsu_xfer;
  logic            mdu_xfer;
  wb_src_e         src;
  logic [AW-1:0]   gnt_rd;
  logic [XLEN-1:0] gnt_data;

  assign lsu_aged = (lsu_cnt == LIM);
  assign mdu_aged = (mdu_cnt == LIM);
  assign alu_hold = lsu_aged | mdu_aged;

  // LSU is the default winner; MDU gets the port when LSU is idle or MDU is aged.
  assign lsu_ready = resetn && !alu_valid && (lsu_aged || !mdu_aged);
  assign mdu_ready = resetn && !alu_valid && !lsu_aged && (mdu_aged || !lsu_valid);
  assign lsu_xfer  = lsu_valid && lsu_ready;
  assign mdu_xfer  = mdu_valid && mdu_ready;

  always_comb begin
    src      = SRC_NONE;
    gnt_rd   = '0;
    gnt_data = '0;
    if (alu_valid) begin
      src      = SRC_ALU;
      gnt_rd   = alu_rd;
      gnt_data = alu_data;
    end else if (lsu_xfer) begin
      src      = SRC_LSU;
      gnt_rd   = lsu_rd;
      gnt_data = lsu_data;
    end else if (mdu_xfer) begin
      src      = SRC_MDU;
      gnt_rd   = mdu_rd;
      gnt_data = mdu_data;
    end
  end

  // Stage boundary: granted result and starvation counters registered.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lsu_cnt    <= '0;
      mdu_cnt    <= '0;
      reg_write  <= 1'b0;
      rd         <= '0;
      write_data <= '0;
    end else begin
      lsu_cnt   <= (!lsu_valid || lsu_xfer) ? '0 : sat_inc(lsu_cnt);
      mdu_cnt   <= (!mdu_valid || mdu_xfer) ? '0 : sat_inc(mdu_cnt);
      reg_write <= (src != SRC_NONE) && (gnt_rd != '0);
      if (src != SRC_NONE) begin
        rd         <= gnt_rd;
        write_data <= gnt_data;
      end
    end
  end

  wb_scoreboard #(.NREG(NREG), .AW(AW)) u_sb (
    .clk       (clk),
    .resetn    (resetn),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .reg_write (reg_write),
    .rd        (rd),
    .busy      (busy)
  );

`ifdef REGFILE_WB_FORWARD_EN
  assign fwd1_hit  = reg_write && (rd != '0) && (rd == rs1);
  assign fwd2_hit  = reg_write && (rd != '0) && (rd == rs2);
  assign fwd1_data = write_data;
  assign fwd2_data = write_data;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        resetn;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        mdu_valid, mdu_ready;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        reg_write;
  logic [4:0]  rd;
  logic [31:0] write_data;
  logic [31:0] busy;
  logic        alu_hold;
`ifdef REGFILE_WB_FORWARD_EN
  logic [4:0]  rs1, rs2;
  logic        fwd1_hit, fwd2_hit;
  logic [31:0] fwd1_data, fwd2_data;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk(clk), .resetn(resetn),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .reg_write(reg_write), .rd(rd), .write_data(write_data), .busy(busy),
`ifdef REGFILE_WB_FORWARD_EN
    .rs1(rs1), .rs2(rs2), .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
    .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
`endif
    .alu_hold(alu_hold)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b1; lsu_rd = 5'd9;  lsu_data = 32'h1111;
    mdu_valid = 1'b1; mdu_rd = 5'd10; mdu_data = 32'h2222;
    iss_valid = 1'b0; iss_rd = '0;
`ifdef REGFILE_WB_FORWARD_EN
    rs1 = '0; rs2 = '0;
`endif
    step(); step();
    check("rst_lsu_ready", lsu_ready, 0);
    check("rst_mdu_ready", mdu_ready, 0);
    check("rst_reg_write", reg_write, 0);
    check("rst_rd", rd, 0);
    check("rst_write_data", write_data, 0);
    check("rst_busy", busy, 0);
    check("rst_alu_hold", alu_hold, 0);

    // Release: LSU wins over MDU, then MDU once LSU idles.
    resetn = 1'b1; #1;
    check("rel_lsu_ready", lsu_ready, 1);
    check("rel_mdu_ready", mdu_ready, 0);
    step();
    check("rel_lsu_wr", reg_write, 1);
    check("rel_lsu_rd", rd, 9);
    check("rel_lsu_data", write_data, 32'h1111);
    lsu_valid = 1'b0; #1;
    check("mdu_ready_idle_lsu", mdu_ready, 1);
    step();
    check("mdu_wr_rd", rd, 10);
    check("mdu_wr_data", write_data, 32'h2222);
    mdu_valid = 1'b0;

    // Plain ALU write.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    step();
    check("alu_wr", reg_write, 1);
    check("alu_rd", rd, 5);
    check("alu_data", write_data, 32'hDEADBEEF);
    alu_valid = 1'b0;
    step();
    check("alu_idle_wr", reg_write, 0);

    // LSU starved by ALU until it ages.
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h66;
    lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_data = 32'h88;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("starve_lsu_ready%0d", i), lsu_ready, 0);
      check($sformatf("starve_hold%0d", i), alu_hold, 0);
      step();
      check($sformatf("starve_alu_rd%0d", i), rd, 6);
    end
    check("aged_hold", alu_hold, 1);
    alu_valid = 1'b0; #1;
    check("aged_lsu_ready", lsu_ready, 1);
    step();
    check("aged_lsu_rd", rd, 8);
    check("aged_lsu_data", write_data, 32'h88);
    check("aged_hold_clr", alu_hold, 0);

    // MDU starved by LSU back-to-back writes, then aged MDU takes priority.
    mdu_valid = 1'b1; mdu_rd = 5'd11; mdu_data = 32'hAB;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("b2b_wr%0d", i), reg_write, 1);
      check($sformatf("b2b_rd%0d", i), rd, 8);
    end
    check("mdu_aged_ready", mdu_ready, 1);
    check("mdu_aged_lsu_ready", lsu_ready, 0);
    check("mdu_aged_hold", alu_hold, 1);
    step();
    check("mdu_aged_rd", rd, 11);
    check("mdu_aged_data", write_data, 32'hAB);
    check("mdu_aged_hold_clr", alu_hold, 0);
    check("lsu_back_ready", lsu_ready, 1);
    lsu_valid = 1'b0; mdu_valid = 1'b0;
    step();

    // Scoreboard set, clear, set-wins.
    iss_valid = 1'b1; iss_rd = 5'd7;
    step();
    iss_valid = 1'b0;
    check("sb_set7", busy, 32'h80);
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h77;
    step();
    lsu_valid = 1'b0;
    check("sb_wr7", reg_write, 1);
    check("sb_still7", busy, 32'h80);
    step();
    check("sb_clr7", busy, 0);
    iss_valid = 1'b1; iss_rd = 5'd7;
    step();
    iss_valid = 1'b0;
    lsu_valid = 1'b1;
    step();
    lsu_valid = 1'b0;
    iss_valid = 1'b1; iss_rd = 5'd7;
    step();
    iss_valid = 1'b0;
    check("sb_setwins", busy, 32'h80);
    step();
    check("sb_setwins_hold", busy, 32'h80);
    iss_valid = 1'b1; iss_rd = 5'd0;
    lsu_valid = 1'b1;
    step();
    iss_valid = 1'b0; lsu_valid = 1'b0;
    step();
    check("sb_final_clr", busy, 0);

    // rd = 0 consumed without a write.
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
    step();
    alu_valid = 1'b0;
    check("x0_no_write", reg_write, 0);
    check("x0_busy", busy, 0);

`ifdef REGFILE_WB_FORWARD_EN
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h333;
    rs1 = 5'd3; rs2 = 5'd4;
    step();
    alu_valid = 1'b0;
    check("fwd1_hit", fwd1_hit, 1);
    check("fwd1_data", fwd1_data, 32'h333);
    check("fwd2_hit", fwd2_hit, 0);
`endif

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
